muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit for the execute stage.
//  - Consumes the two register-file read operands (rs1/rs2 data) plus the destination index.
//  - Returns its result through the register-file write port (wr_en/wr_addr/wr_data) via a valid/ready writeback handshake.
//  - One operation in flight; the pipeline stalls on busy.
// PARAMETERS
//  XLEN  32  operand/result width; the iteration count equals XLEN
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst_n      in   1     reset, asynchronous, active-low
//  start      in   1     request; accepted only in IDLE
//  funct3     in   3     RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  rs1_data   in   XLEN  operand A (register-file read port 1)
//  rs2_data   in   XLEN  operand B (register-file read port 2)
//  rd_addr    in   5     destination register index
//  flush      in   1     synchronous abort of the in-flight op
//  busy       out  1     high in every state except IDLE
//  wb_valid   out  1     result available; drives the register-file wr_en
//  wb_ready   in   1     writeback slot granted this cycle
//  wb_addr    out  5     destination index; drives wr_addr
//  wb_data    out  XLEN  result; drives wr_data
// BEHAVIOUR
//  Reset (rst_n low, any state): state=IDLE; busy, wb_valid, wb_addr, wb_data, all internal registers = 0.
//  States and transitions:
//   - IDLE -> CALC on start.
//     Latch funct3 and rd_addr.
//     Latch |rs1|/|rs2| per signedness: MULH/DIV/REM treat both operands as signed.
//     MULHSU: rs1 signed, rs2 unsigned.
//     Latch the result-sign flags; load counter = XLEN.
//   - IDLE -> DONE directly (special case, no CALC).
//     Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
//     Signed overflow (DIV/REM, rs1=0x8000_0000, rs2=0xFFFF_FFFF): DIV -> 0x8000_0000; REM -> 0.
//   - CALC: one radix-2 step per cycle, XLEN cycles.
//     Multiply: shift-add into a 2*XLEN accumulator.
//     Divide: restoring shift-subtract, quotient/remainder registers.
//     counter==1 -> FIXUP.
//   - FIXUP (1 cycle): conditional two's-complement negation.
//     Multiply: negate the full 2*XLEN product, then select the half.
//     Quotient sign = sA^sB; remainder sign = sA.
//     Select the result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
//     Register it into wb_data -> DONE.
//   - DONE: wb_valid=1; wb_data and wb_addr held stable until wb_valid&&wb_ready at a posedge.
//     On that handshake: -> IDLE and wb_valid drops the next cycle.
//  Latency: start edge to wb_valid high = XLEN+2 cycles (34) normal; 1 cycle for special cases.
//  start while busy: ignored; no state change. start with flush in the same IDLE cycle: flush wins (not accepted).
//  flush: any state -> IDLE next edge; wb_valid cleared; no writeback issued.
//  rd_addr=0: computed and written back normally (the register file discards writes to x0).
//  All arithmetic is modulo 2^XLEN; the multiply accumulator is 2*XLEN wide, with no overflow flags.
// TESTING
//  - MUL 7*(-3): rs1=7, rs2=0xFFFF_FFFD -> wb_data=0xFFFF_FFEB, wb_valid 34 cycles after start.
//  - MULH/MULHU/MULHSU with rs1=0x8000_0000, rs2=0x8000_0000 -> MULH 0x4000_0000; MULHU 0x4000_0000; MULHSU 0xC000_0000.
//  - DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  - Special cases, each wb_valid 1 cycle after start:
//    DIV 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000; REM same operands -> 0.
//  - Backpressure: hold wb_ready=0 for 10 cycles -> wb_valid/wb_data/wb_addr stable, busy=1, a second start ignored;
//    raising wb_ready -> one writeback, then IDLE.
//  - Abort: flush at CALC cycle 10 -> IDLE next cycle, no wb_valid.
//    rst_n low mid-CALC -> all outputs 0 immediately; a following op runs correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit for the execute stage. One operation
// is in flight at a time; the pipeline stalls while busy is high. Results
// leave through a valid/ready writeback port that feeds the register-file
// write port directly.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   start     request, accepted only while idle
//   funct3    RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                       4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_data  operand A
//   rs2_data  operand B
//   rd_addr   destination register index
//   flush     synchronous abort of the in-flight operation
//   busy      high in every state except IDLE
//   wb_valid  result available (register-file wr_en)
//   wb_ready  writeback slot granted this cycle
//   wb_addr   destination index (register-file wr_addr)
//   wb_data   result (register-file wr_data)

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    // ------------------------------------------------------------------
    // Operand decode at issue time
    // ------------------------------------------------------------------
    logic            is_div_in;
    logic            a_signed_in;
    logic            b_signed_in;
    logic            sign_a_in;
    logic            sign_b_in;
    logic [XLEN-1:0] abs_a_in;
    logic [XLEN-1:0] abs_b_in;
    logic            div_zero_in;
    logic            div_ovf_in;
    logic            special_in;
    logic [XLEN-1:0] special_result;

    assign is_div_in   = funct3[2];
    // MULH, MULHSU, DIV and REM treat rs1 as signed; rs2 is signed only
    // for MULH, DIV and REM. MUL's low half is sign-agnostic.
    assign a_signed_in = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                         (funct3 == 3'd4) || (funct3 == 3'd6);
    assign b_signed_in = (funct3 == 3'd1) || (funct3 == 3'd4) ||
                         (funct3 == 3'd6);
    assign sign_a_in   = a_signed_in && rs1_data[XLEN-1];
    assign sign_b_in   = b_signed_in && rs2_data[XLEN-1];
    assign abs_a_in    = sign_a_in ? -rs1_data : rs1_data;
    assign abs_b_in    = sign_b_in ? -rs2_data : rs2_data;

    // Divide-by-zero and the single signed-overflow case have fixed
    // architectural results, so they bypass the iteration entirely.
    assign div_zero_in = is_div_in && (rs2_data == '0);
    assign div_ovf_in  = is_div_in && !funct3[0] &&
                         (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (rs2_data == '1);
    assign special_in  = div_zero_in || div_ovf_in;

    always_comb begin
        special_result = '0;
        if (div_zero_in) begin
            special_result = funct3[1] ? rs1_data : '1;
        end else if (div_ovf_in) begin
            special_result = funct3[1] ? '0 : rs1_data;
        end
    end

    // ------------------------------------------------------------------
    // One radix-2 step of each algorithm
    // ------------------------------------------------------------------
    // Multiply: acc = {high partial, remaining multiplier bits}. The sum
    // keeps its carry so the right shift loses nothing.
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_addend = acc_q[0] ? opb_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}.
    // The shifted remainder needs one extra bit since the divisor may use
    // the full XLEN range. When the subtraction is not taken, the shifted
    // remainder is below the divisor so its top bit is necessarily zero.
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_next;

    assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, opb_q};
    assign rem_sub   = rem_shift[XLEN-1:0] - opb_q;
    assign div_next  = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                              : {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_result;

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        final_result = '0;
        case (op_q)
            3'd0:       final_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       final_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: final_result = quot_fix;
            default:    final_result = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        wb_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = special_in ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything, including a same-cycle start or a
        // same-cycle writeback grant.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q     <= funct3;
                        sign_a_q <= sign_a_in;
                        sign_b_q <= sign_b_in;
                        opb_q    <= abs_b_in;
                        acc_q    <= {{XLEN{1'b0}}, abs_a_in};
                        cnt_q    <= CW'(XLEN);
                        wb_addr  <= rd_addr;
                        if (special_in) begin
                            wb_data <= special_result;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIXUP: begin
                    wb_data <= final_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized
// operations against an arithmetic reference model, backpressure, flush
// and asynchronous reset in the middle of an operation.

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .flush    (flush),
        .busy     (busy),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        int ia, ib;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        return f[2] && ((b == 0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, measure start-to-valid latency, check result, retire it.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] expData, input int expLat);
        int cyc;
        bit seen;
        @(negedge clk);
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_addr  = rd;
        start    = 1'b1;
        wb_ready = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            seen = wb_valid;
        end
        checkOutput($sformatf("latency f%0d", f), 64'(cyc), 64'(expLat));
        checkOutput($sformatf("data f%0d %h/%h", f, a, b), 64'(wb_data), 64'(expData));
        checkOutput("addr", 64'(wb_addr), 64'(rd));
        @(negedge clk);
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        checkOutput("retire busy/valid", 64'({busy, wb_valid}), 64'(0));
    endtask

    logic [2:0]  dF [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] dA [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dB [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dR [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          dL [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

    initial begin : main
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        logic [4:0]  rd;
        int cyc;
        bit seen;

        // Reset state
        #1;
        checkOutput("reset outputs", 64'({busy, wb_valid, wb_addr, wb_data}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset busy", 64'(busy), 64'(0));

        // Directed cases
        for (int i = 0; i < 12; i++) begin
            applyStimulus(dF[i], dA[i], dB[i], 5'(i + 1), dR[i], dL[i]);
        end

        // Randomized ops against the reference model (rd=0 included)
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            rd = 5'($urandom_range(0, 31));
            applyStimulus(f, a, b, rd, refModel(f, a, b), isSpecial(f, a, b) ? 1 : 34);
        end

        // Backpressure: result held, second start ignored, one writeback
        a   = $urandom;
        b   = $urandom;
        exp = refModel(3'd3, a, b);
        @(negedge clk);
        funct3 = 3'd3; rs1_data = a; rs2_data = b; rd_addr = 5'd9; start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            seen = wb_valid;
        end
        checkOutput("bp latency", 64'(cyc), 64'(34));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1; funct3 = 3'd0; rs1_data = 32'd1; rs2_data = 32'd1; rd_addr = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            checkOutput("bp hold", 64'({busy, wb_valid, wb_addr, wb_data}),
                        64'({1'b1, 1'b1, 5'd9, exp}));
        end
        start = 1'b0;
        @(negedge clk);
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        checkOutput("bp retire", 64'({busy, wb_valid}), 64'(0));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (wb_valid || busy) seen = 1'b1;
        end
        checkOutput("bp no second op", 64'(seen), 64'(0));

        // Flush at CALC cycle 10
        @(negedge clk);
        funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush idle", 64'({busy, wb_valid}), 64'(0));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (wb_valid) seen = 1'b1;
        end
        checkOutput("flush no writeback", 64'(seen), 64'(0));

        // start and flush together: not accepted
        @(negedge clk);
        funct3 = 3'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checkOutput("start+flush", 64'(busy), 64'(0));

        // Asynchronous reset mid-CALC, then a normal op
        @(negedge clk);
        funct3 = 3'd0; rs1_data = 32'd12345; rs2_data = 32'd678; rd_addr = 5'd17; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset", 64'({busy, wb_valid, wb_addr, wb_data}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'hFFFF_FF00;
        b = 32'd37;
        applyStimulus(3'd6, a, b, 5'd21, refModel(3'd6, a, b), 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
